// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : RV32 instruction fetch. Owns the PC, issues one word fetch at a
//            time, handles branch/jump redirects and buffers returned words
//            in a 2-entry FIFO presented to decode as {inst, pc}.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [Width-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [Width-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [Width-1:0] id_inst,
  output logic [Width-1:0] id_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] inflight_pc_q, inflight_pc_d;
  logic             kill_q, kill_d;
  logic [1:0]       count_q, count_d;
  logic [Width-1:0] e0_inst_q, e0_inst_d, e0_pc_q, e0_pc_d;
  logic [Width-1:0] e1_inst_q, e1_inst_d, e1_pc_q, e1_pc_d;

  logic w_redirect;
  logic w_handshake;
  logic w_push;
  logic w_pop;

  // Redirects are ignored while the machine is still leaving reset.
  assign w_redirect  = redirect_valid && (state_q != S_IDLE);
  assign w_handshake = imem_req_valid && imem_req_ready;
  // A response is kept only when it belongs to the live request stream.
  assign w_push      = (state_q == S_WAIT) && imem_rsp_valid && !kill_q && !w_redirect;
  assign w_pop       = id_valid && id_ready;

  // Issue only with a free FIFO slot so a returning word always fits.
  assign imem_req_valid = (state_q == S_REQ) && (count_q < 2'd2);
  assign imem_req_addr  = pc_q;
  assign id_valid       = (count_q != 2'd0);
  assign id_inst        = e0_inst_q;
  assign id_pc          = e0_pc_q;

  // Fetch control: state, PC, in-flight address and stale-response kill flag.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    kill_d        = kill_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (w_handshake) begin
          state_d       = S_WAIT;
          inflight_pc_d = pc_q;
          // The request just issued is already stale if a redirect coincides.
          if (w_redirect) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (w_push) pc_d = inflight_pc_q + Width'(4);
        end else if (w_redirect) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect target is word-aligned by clearing the low two bits.
    if (w_redirect) pc_d = redirect_pc & ~Width'(3);
  end

  // FIFO bookkeeping: entry 0 is always the head; flush wins over push/pop.
  always_comb begin
    count_d   = count_q;
    e0_inst_d = e0_inst_q;
    e0_pc_d   = e0_pc_q;
    e1_inst_d = e1_inst_q;
    e1_pc_d   = e1_pc_q;
    if (w_redirect) begin
      count_d = 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_inst_d = imem_rsp_data;
            e0_pc_d   = inflight_pc_q;
          end else begin
            e0_inst_d = e1_inst_q;
            e0_pc_d   = e1_pc_q;
            e1_inst_d = imem_rsp_data;
            e1_pc_d   = inflight_pc_q;
          end
        end
        2'b01: begin
          e0_inst_d = e1_inst_q;
          e0_pc_d   = e1_pc_q;
          count_d   = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            e0_inst_d = imem_rsp_data;
            e0_pc_d   = inflight_pc_q;
          end else begin
            e1_inst_d = imem_rsp_data;
            e1_pc_d   = inflight_pc_q;
          end
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      count_q       <= 2'd0;
      e0_inst_q     <= '0;
      e0_pc_q       <= '0;
      e1_inst_q     <= '0;
      e1_pc_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      e0_inst_q     <= e0_inst_d;
      e0_pc_q       <= e0_pc_d;
      e1_inst_q     <= e1_inst_d;
      e1_pc_q       <= e1_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage. Instance a uses
//            RESET_PC=0, instance b uses RESET_PC=0xFFFF_FFFC; both share the
//            stimulus inputs but have independent resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_n_b = 1'b0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        id_ready = 1'b0;

  logic        req_valid, req_valid_b;
  logic [31:0] req_addr, req_addr_b;
  logic        id_valid, id_valid_b;
  logic [31:0] id_inst, id_inst_b, id_pc, id_pc_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_stage #(.Width(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir), .redirect_pc(redir_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  fetch_stage #(.Width(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .imem_req_valid(req_valid_b), .imem_req_ready(req_ready), .imem_req_addr(req_addr_b),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redir), .redirect_pc(redir_pc),
    .id_valid(id_valid_b), .id_ready(id_ready), .id_inst(id_inst_b), .id_pc(id_pc_b)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid actual=%0h expected=0", req_valid); end
    checks++; if (req_addr !== 32'h0) begin failures++; $display("FAIL rst_req_addr actual=%08h expected=00000000", req_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_id_valid actual=%0h expected=0", id_valid); end
    checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0) begin failures++; $display("FAIL rst_id_data actual=%08h/%08h expected=0/0", id_inst, id_pc); end
    checks++; if (req_addr_b !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_b_req_addr actual=%08h expected=fffffffc", req_addr_b); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    tick();  // IDLE -> REQ
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin failures++; $display("FAIL t1_first_req actual=%0h/%08h expected=1/00000000", req_valid, req_addr); end
    req_ready = 1'b1;
    tick();  // handshake -> WAIT
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL t1_wait_no_req actual=%0h expected=0", req_valid); end
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    tick();  // push
    rsp_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_inst !== 32'h0050_0093 || id_pc !== 32'h0) begin failures++; $display("FAIL t1_id_out actual=%0h/%08h/%08h expected=1/00500093/00000000", id_valid, id_inst, id_pc); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h4) begin failures++; $display("FAIL t1_next_req actual=%0h/%08h expected=1/00000004", req_valid, req_addr); end
  endtask

  task automatic test_fifo_full();
    id_ready = 1'b0; req_ready = 1'b1;
    tick();  // handshake addr 4
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h00A0_0113;
    tick();  // push second entry, FIFO full
    rsp_valid = 1'b0;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL t2_full_gate actual=%0h expected=0", req_valid); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'h0050_0093) begin failures++; $display("FAIL t2_head0 actual=%0h/%08h/%08h expected=1/00000000/00500093", id_valid, id_pc, id_inst); end
    req_ready = 1'b1;
    tick();  // still full, no issue despite ready
    checks++; if (req_valid !== 1'b0 || id_pc !== 32'h0) begin failures++; $display("FAIL t2_hold actual=%0h/%08h expected=0/00000000", req_valid, id_pc); end
    req_ready = 1'b0; id_ready = 1'b1;
    tick();  // pop pc 0
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== 32'h00A0_0113) begin failures++; $display("FAIL t2_head1 actual=%0h/%08h/%08h expected=1/00000004/00a00113", id_valid, id_pc, id_inst); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8) begin failures++; $display("FAIL t2_resume actual=%0h/%08h expected=1/00000008", req_valid, req_addr); end
    tick();  // pop pc 4
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL t2_empty actual=%0h expected=0", id_valid); end
    id_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    req_ready = 1'b1;
    tick();  // handshake addr 8
    req_ready = 1'b0; redir = 1'b1; redir_pc = 32'h100;
    tick();  // redirect in WAIT, no response yet
    redir = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    tick();  // stale response dropped
    rsp_valid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL t3_dropped actual=%0h expected=0", id_valid); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin failures++; $display("FAIL t3_new_req actual=%0h/%08h expected=1/00000100", req_valid, req_addr); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
    tick();
    rsp_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'h1111_1111) begin failures++; $display("FAIL t3_target_fetch actual=%0h/%08h/%08h expected=1/00000100/11111111", id_valid, id_pc, id_inst); end
  endtask

  task automatic test_redirect_full();
    req_ready = 1'b1;
    tick();  // handshake addr 0x104
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h2222_2222;
    tick();  // FIFO full
    rsp_valid = 1'b0;
    checks++; if (req_valid !== 1'b0 || req_addr !== 32'h108) begin failures++; $display("FAIL t4_full actual=%0h/%08h expected=0/00000108", req_valid, req_addr); end
    redir = 1'b1; redir_pc = 32'h103; id_ready = 1'b1;
    tick();  // flush, same-cycle pop ignored
    redir = 1'b0; id_ready = 1'b0;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL t4_flush actual=%0h expected=0", id_valid); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin failures++; $display("FAIL t4_aligned actual=%0h/%08h expected=1/00000100", req_valid, req_addr); end
  endtask

  task automatic test_redirect_same_cycle();
    req_ready = 1'b1;
    tick();  // handshake addr 0x100
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h3333_3333; redir = 1'b1; redir_pc = 32'h40;
    tick();  // response and redirect together
    rsp_valid = 1'b0; redir = 1'b0;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL t5_rsp_redir_drop actual=%0h expected=0", id_valid); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h40) begin failures++; $display("FAIL t5_req40 actual=%0h/%08h expected=1/00000040", req_valid, req_addr); end
    req_ready = 1'b1; redir = 1'b1; redir_pc = 32'h80;
    tick();  // handshake on 0x40 with redirect
    req_ready = 1'b0; redir = 1'b0;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL t5_wait_killed actual=%0h expected=0", req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'h4444_4444;
    tick();  // stale response dropped
    rsp_valid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL t5_stale_drop actual=%0h expected=0", id_valid); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h80) begin failures++; $display("FAIL t5_req80 actual=%0h/%08h expected=1/00000080", req_valid, req_addr); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h5555_5555;
    tick();  // kill cleared: this response is kept
    rsp_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_inst !== 32'h5555_5555) begin failures++; $display("FAIL t5_kill_cleared actual=%0h/%08h/%08h expected=1/00000080/55555555", id_valid, id_pc, id_inst); end
  endtask

  task automatic test_wrap_and_async_reset();
    id_ready = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; redir = 1'b0;
    @(negedge clk);
    rst_n_b = 1'b1;
    tick();  // IDLE -> REQ
    checks++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'hFFFF_FFFC) begin failures++; $display("FAIL t6_first_req actual=%0h/%08h expected=1/fffffffc", req_valid_b, req_addr_b); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h6666_6666;
    tick();
    rsp_valid = 1'b0;
    checks++; if (id_valid_b !== 1'b1 || id_pc_b !== 32'hFFFF_FFFC || id_inst_b !== 32'h6666_6666) begin failures++; $display("FAIL t6_id_top actual=%0h/%08h/%08h expected=1/fffffffc/66666666", id_valid_b, id_pc_b, id_inst_b); end
    checks++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'h0) begin failures++; $display("FAIL t6_wrap actual=%0h/%08h expected=1/00000000", req_valid_b, req_addr_b); end
    req_ready = 1'b1;
    tick();  // handshake addr 0 -> WAIT, FIFO holds one entry
    req_ready = 1'b0;
    #2 rst_n_b = 1'b0;
    #1;
    checks++; if (req_valid_b !== 1'b0 || id_valid_b !== 1'b0) begin failures++; $display("FAIL t6_async_rst actual=%0h/%0h expected=0/0", req_valid_b, id_valid_b); end
    checks++; if (req_addr_b !== 32'hFFFF_FFFC || id_pc_b !== 32'h0) begin failures++; $display("FAIL t6_rst_vals actual=%08h/%08h expected=fffffffc/00000000", req_addr_b, id_pc_b); end
    rsp_valid = 1'b1; rsp_data = 32'h7777_7777;
    @(negedge clk);
    rst_n_b = 1'b1;
    tick();  // IDLE: response ignored
    checks++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'hFFFF_FFFC || id_valid_b !== 1'b0) begin failures++; $display("FAIL t6_restart actual=%0h/%08h/%0h expected=1/fffffffc/0", req_valid_b, req_addr_b, id_valid_b); end
    tick();  // REQ: response ignored
    rsp_valid = 1'b0;
    checks++; if (id_valid_b !== 1'b0 || req_valid_b !== 1'b1) begin failures++; $display("FAIL t6_rsp_in_req actual=%0h/%0h expected=0/1", id_valid_b, req_valid_b); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_fifo_full();
    test_redirect_wait();
    test_redirect_full();
    test_redirect_same_cycle();
    test_wrap_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
